// File: rtl/cave_video_pkg.sv
// cave_video_pkg: shared pixel/word geometry and the underflow marker colour for the video read path.
package cave_video_pkg;
   localparam int PIXEL_WIDTH = 16;
   localparam int WORD_WIDTH = 32;
   localparam int PIXELS_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
   localparam int COUNT_WIDTH = 16;
   typedef logic [PIXEL_WIDTH-1:0] pixel_t;
   localparam pixel_t UNDERFLOW_COLOR = 16'h7C1F;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);
   always_ff @(posedge clock)
      value <= clear ? '0 : (inc && !(&value)) ? value + WIDTH'(1) : value;
endmodule

// File: rtl/fifo_pixel_unpacker.sv
// fifo_pixel_unpacker: pops FIFO words and emits one registered pixel per active-display cycle,
// realigning on each vertical-blank rise and tallying underflow cycles.
module fifo_pixel_unpacker #(
   parameter int                     WORD_WIDTH      = cave_video_pkg::WORD_WIDTH,
   parameter int                     PIXEL_WIDTH     = cave_video_pkg::PIXEL_WIDTH,
   parameter logic [PIXEL_WIDTH-1:0] UNDERFLOW_COLOR = cave_video_pkg::UNDERFLOW_COLOR,
   parameter int                     COUNT_WIDTH     = cave_video_pkg::COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   io_deq_ready,
   input  logic                   io_deq_valid,
   input  logic [WORD_WIDTH-1:0]  io_deq_bits,
   input  logic                   io_video_enable,
   input  logic                   io_video_vBlank,
   output logic                   io_pixel_valid,
   output logic [PIXEL_WIDTH-1:0] io_pixel_bits,
   output logic                   io_underflow,
   output logic [COUNT_WIDTH-1:0] io_underflowCount
);
   localparam int PIXELS_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
   localparam int CW = $clog2(PIXELS_PER_WORD + 1);
   localparam int IW = PIXELS_PER_WORD > 1 ? $clog2(PIXELS_PER_WORD) : 1;
   logic [WORD_WIDTH-1:0] word;
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic                  vblank_d;
   logic                  vb_rise, xfer, consume, starve;
   assign vb_rise = io_video_vBlank & ~vblank_d;
   // Accept the next word on the same edge the last pixel leaves, so streaming has no bubble.
   assign io_deq_ready = ~reset & ~vb_rise & ((cnt == '0) | ((cnt == CW'(1)) & io_video_enable));
   assign xfer = io_deq_ready & io_deq_valid;
   assign consume = io_video_enable & ~vb_rise & (cnt != '0);
   assign starve = io_video_enable & ~vb_rise & (cnt == '0);
   always_ff @(posedge clock) begin
      if (reset) begin
         word <= '0;
         cnt <= '0;
         idx <= '0;
         vblank_d <= 1'b0;
         io_pixel_valid <= 1'b0;
         io_pixel_bits <= '0;
         io_underflow <= 1'b0;
      end else begin
         vblank_d <= io_video_vBlank;
         io_pixel_valid <= consume;
         if (vb_rise) begin
            cnt <= '0;
            idx <= '0;
            io_underflow <= 1'b0;
         end
         if (consume) begin
            io_pixel_bits <= word[idx*PIXEL_WIDTH +: PIXEL_WIDTH];
            idx <= idx + IW'(1);
            cnt <= cnt - CW'(1);
         end
         if (starve) begin
            io_pixel_bits <= UNDERFLOW_COLOR;
            io_underflow <= 1'b1;
         end
         // A fresh word overrides this cycle's decrement.
         if (xfer) begin
            word <= io_deq_bits;
            cnt <= CW'(PIXELS_PER_WORD);
            idx <= '0;
         end
      end
   end
   sat_counter #(.WIDTH(COUNT_WIDTH)) u_underflow_count (
      .clock(clock),
      .clear(reset),
      .inc(starve),
      .value(io_underflowCount)
   );
endmodule
